// File: rtl/sync_arbiter_pkg.sv
// Shared types and constants for the sync_arbiter strobe/handshake arbiter.
package sync_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STROBE = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam int MAX_CHANNELS = 8;

endpackage

// File: rtl/sync_arbiter_rr_picker.sv
// Combinational round-robin picker: first requesting channel at or after
// `start`, wrapping around to channel 0.
module rr_picker #(
    parameter int CHANNELS = 2,
    parameter int GW       = 1
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [GW-1:0]       start,
    output logic                valid,
    output logic [GW-1:0]       idx
);

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        // First pass covers start..top, second pass wraps from channel 0.
        for (int j = 0; j < CHANNELS; j++) begin
            if (!valid && req[j] && (j >= int'(start))) begin
                valid = 1'b1;
                idx   = GW'(j);
            end
        end
        for (int j = 0; j < CHANNELS; j++) begin
            if (!valid && req[j]) begin
                valid = 1'b1;
                idx   = GW'(j);
            end
        end
    end

endmodule

// File: rtl/sync_arbiter.sv
// Multi-channel strobe/done handshake arbiter (IDLE -> STROBE -> DONE).
// Define SYNC_ARBITER_FIXED_PRIORITY_EN for lowest-index-wins arbitration.
module sync_arbiter
    import sync_arbiter_pkg::*;
#(
    parameter int CHANNELS      = 2,
    parameter int STROBE_CYCLES = 1
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [CHANNELS-1:0]                     pending,
    output logic [CHANNELS-1:0]                     strobe,
    output logic [CHANNELS-1:0]                     done,
    output logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] grant,
    output logic                                    busy
);

    localparam int GW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int CW = $clog2(STROBE_CYCLES + 1);

    state_t              state_q, state_n;
    logic [CW-1:0]       cnt_q, cnt_n;
    logic [GW-1:0]       grant_q, grant_n;
    logic [CHANNELS-1:0] strobe_q, strobe_n;
    logic [CHANNELS-1:0] done_q, done_n;
    logic                busy_q, busy_n;
    logic                pick_valid;
    logic [GW-1:0]       pick_idx;

`ifdef SYNC_ARBITER_FIXED_PRIORITY_EN
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int j = CHANNELS - 1; j >= 0; j--) begin
            if (pending[j]) begin
                pick_valid = 1'b1;
                pick_idx   = GW'(j);
            end
        end
    end
`else
    logic [GW-1:0] ptr_q;

    rr_picker #(
        .CHANNELS (CHANNELS),
        .GW       (GW)
    ) u_picker (
        .req   (pending),
        .start (ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // Search restarts just past the channel most recently granted.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
        end else if (state_q == IDLE && pick_valid) begin
            ptr_q <= (pick_idx == GW'(CHANNELS - 1)) ? '0 : pick_idx + GW'(1);
        end
    end
`endif

    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        grant_n = grant_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_n = STROBE;
                    grant_n = pick_idx;
                    cnt_n   = CW'(STROBE_CYCLES - 1);
                end
            end
            STROBE: begin
                if (cnt_q == '0) state_n = DONE;
                else             cnt_n   = cnt_q - CW'(1);
            end
            DONE: begin
                if (!pending[grant_q]) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        // Outputs are decoded from the next state so they leave a flop.
        strobe_n = (state_n == STROBE) ? (CHANNELS'(1) << grant_n) : '0;
        done_n   = (state_n == DONE)   ? (CHANNELS'(1) << grant_n) : '0;
        busy_n   = (state_n != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            grant_q  <= '0;
            strobe_q <= '0;
            done_q   <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_n;
            cnt_q    <= cnt_n;
            grant_q  <= grant_n;
            strobe_q <= strobe_n;
            done_q   <= done_n;
            busy_q   <= busy_n;
        end
    end

    assign strobe = strobe_q;
    assign done   = done_q;
    assign grant  = grant_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_sync_arbiter.sv
// Bench for sync_arbiter: directed vector table, a random phase checked
// against a behavioural model, and a single-channel instance check.
module tb_sync_arbiter;

    localparam int CH = 4;
    localparam int SC = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] pending;
    logic [3:0] strobe;
    logic [3:0] done;
    logic [1:0] grant;
    logic       busy;

    logic reset1;
    logic pending1;
    logic strobe1;
    logic done1;
    logic grant1;
    logic busy1;

    always #5 clk = ~clk;

    sync_arbiter #(.CHANNELS(CH), .STROBE_CYCLES(SC)) dut (
        .clk     (clk),
        .reset   (reset),
        .pending (pending),
        .strobe  (strobe),
        .done    (done),
        .grant   (grant),
        .busy    (busy)
    );

    sync_arbiter #(.CHANNELS(1), .STROBE_CYCLES(1)) dut1 (
        .clk     (clk),
        .reset   (reset1),
        .pending (pending1),
        .strobe  (strobe1),
        .done    (done1),
        .grant   (grant1),
        .busy    (busy1)
    );

    typedef struct {
        string      tag;
        logic       rst;
        logic [3:0] pend;
        logic [3:0] strb;
        logic [3:0] dn;
        logic       bsy;
        logic [1:0] gnt;
    } vec_t;

    vec_t        vecs[$];
    logic [10:0] exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    // model state for the random phase
    int          m_st;
    int          m_cnt;
    logic [1:0]  m_g;
    logic [1:0]  m_ptr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input string tag, input logic r, input logic [3:0] p,
                       input logic [3:0] s, input logic [3:0] d, input logic b,
                       input logic [1:0] g);
        vec_t v;
        v.tag = tag; v.rst = r; v.pend = p;
        v.strb = s; v.dn = d; v.bsy = b; v.gnt = g;
        vecs.push_back(v);
    endtask

    task automatic sample(input string tag);
        logic [10:0] e;
        if (exp_q.size() == 0) begin
            check({tag, "_queue_empty"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check(tag, {21'd0, strobe, done, busy, grant}, {21'd0, e});
        end
        check({tag, "_no_overlap"}, {28'd0, strobe & done}, 32'd0);
        check({tag, "_onehot"}, {31'd0, $onehot0(strobe) && $onehot0(done)}, 32'd1);
    endtask

    task automatic drive(input string tag, input logic r, input logic [3:0] p,
                         input logic [10:0] e);
        reset   = r;
        pending = p;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        sample(tag);
    endtask

    task automatic model_step(input logic r, input logic [3:0] p, output logic [10:0] e);
        logic       found;
        logic [1:0] idx;
        logic [3:0] s;
        logic [3:0] d;
        if (r) begin
            m_st = 0; m_cnt = 0; m_g = 2'd0; m_ptr = 2'd0;
        end else begin
            case (m_st)
                0: if (p != 4'd0) begin
                    found = 1'b0;
                    for (int i = 0; i < 4; i++) begin
`ifdef SYNC_ARBITER_FIXED_PRIORITY_EN
                        idx = 2'(i);
`else
                        idx = m_ptr + 2'(i);
`endif
                        if (!found && p[idx]) begin
                            found = 1'b1;
                            m_g   = idx;
                        end
                    end
                    m_ptr = m_g + 2'd1;
                    m_cnt = SC - 1;
                    m_st  = 1;
                end
                1: if (m_cnt == 0) m_st = 2; else m_cnt--;
                2: if (!p[m_g]) m_st = 0;
                default: m_st = 0;
            endcase
        end
        s = (m_st == 1) ? (4'b0001 << m_g) : 4'b0000;
        d = (m_st == 2) ? (4'b0001 << m_g) : 4'b0000;
        e = {s, d, (m_st != 0), m_g};
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  rr_s;
        logic [1:0]  rr_g;
        logic [3:0]  p;
        logic        r;
        logic [10:0] e;

`ifdef SYNC_ARBITER_FIXED_PRIORITY_EN
        rr_s = 4'b0001; rr_g = 2'd0;
`else
        rr_s = 4'b1000; rr_g = 2'd3;
`endif
        //   tag          rst pend     strobe   done     busy gnt
        add("t1_rst",     1, 4'b0000, 4'b0000, 4'b0000, 0, 0);
        add("t1_idle_a",  0, 4'b0000, 4'b0000, 4'b0000, 0, 0);
        add("t1_idle_b",  0, 4'b0000, 4'b0000, 4'b0000, 0, 0);
        add("t2_s1",      0, 4'b0100, 4'b0100, 4'b0000, 1, 2);
        add("t2_s2",      0, 4'b0100, 4'b0100, 4'b0000, 1, 2);
        add("t2_done",    0, 4'b0100, 4'b0000, 4'b0100, 1, 2);
        add("t2_hold_a",  0, 4'b0100, 4'b0000, 4'b0100, 1, 2);
        add("t2_hold_b",  0, 4'b0100, 4'b0000, 4'b0100, 1, 2);
        add("t2_hold_c",  0, 4'b0100, 4'b0000, 4'b0100, 1, 2);
        add("t2_release", 0, 4'b0000, 4'b0000, 4'b0000, 0, 2);
        add("t4_s1",      0, 4'b0010, 4'b0010, 4'b0000, 1, 1);
        add("t4_s2_drop", 0, 4'b0000, 4'b0010, 4'b0000, 1, 1);
        add("t4_done1",   0, 4'b0000, 4'b0000, 4'b0010, 1, 1);
        add("t4_idle",    0, 4'b0000, 4'b0000, 4'b0000, 0, 1);
        add("t3_rst",     1, 4'b0000, 4'b0000, 4'b0000, 0, 0);
        add("t3_g0_s1",   0, 4'b1011, 4'b0001, 4'b0000, 1, 0);
        add("t3_g0_s2",   0, 4'b1011, 4'b0001, 4'b0000, 1, 0);
        add("t3_g0_done", 0, 4'b1011, 4'b0000, 4'b0001, 1, 0);
        add("t3_g0_rel",  0, 4'b1010, 4'b0000, 4'b0000, 0, 0);
        add("t3_g1_s1",   0, 4'b1010, 4'b0010, 4'b0000, 1, 1);
        add("t3_g1_s2",   0, 4'b1010, 4'b0010, 4'b0000, 1, 1);
        add("t3_g1_done", 0, 4'b1010, 4'b0000, 4'b0010, 1, 1);
        add("t3_g1_rel",  0, 4'b1000, 4'b0000, 4'b0000, 0, 1);
        add("t3_g3_s1",   0, 4'b1000, 4'b1000, 4'b0000, 1, 3);
        add("t3_g3_s2",   0, 4'b1000, 4'b1000, 4'b0000, 1, 3);
        add("t3_g3_done", 0, 4'b1000, 4'b0000, 4'b1000, 1, 3);
        add("t3_g3_rel",  0, 4'b0000, 4'b0000, 4'b0000, 0, 3);
        add("t3_c0_s1",   0, 4'b0001, 4'b0001, 4'b0000, 1, 0);
        add("t3_c0_s2",   0, 4'b0001, 4'b0001, 4'b0000, 1, 0);
        add("t3_c0_done", 0, 4'b0001, 4'b0000, 4'b0001, 1, 0);
        add("t3_c0_rel",  0, 4'b0000, 4'b0000, 4'b0000, 0, 0);
        add("t3_pick_s1", 0, 4'b1001, rr_s,    4'b0000, 1, rr_g);
        add("t3_pick_s2", 0, 4'b0000, rr_s,    4'b0000, 1, rr_g);
        add("t3_pick_d",  0, 4'b0000, 4'b0000, rr_s,    1, rr_g);
        add("t3_pick_id", 0, 4'b0000, 4'b0000, 4'b0000, 0, rr_g);
        add("t5_s1",      0, 4'b0010, 4'b0010, 4'b0000, 1, 1);
        add("t5_rst",     1, 4'b0010, 4'b0000, 4'b0000, 0, 0);
        add("t5_re_s1",   0, 4'b0010, 4'b0010, 4'b0000, 1, 1);
        add("t5_re_s2",   0, 4'b0010, 4'b0010, 4'b0000, 1, 1);
        add("t5_re_done", 0, 4'b0010, 4'b0000, 4'b0010, 1, 1);
        add("t5_re_rel",  0, 4'b0000, 4'b0000, 4'b0000, 0, 1);

        reset    = 1'b1;
        pending  = 4'b0000;
        reset1   = 1'b1;
        pending1 = 1'b0;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            drive(vecs[i].tag, vecs[i].rst, vecs[i].pend,
                  {vecs[i].strb, vecs[i].dn, vecs[i].bsy, vecs[i].gnt});
        end

        // random phase: requests toggle per channel, occasional reset
        p = 4'b0000;
        model_step(1'b1, p, e);
        reset = 1'b1; pending = p; exp_q.push_back(e);
        @(posedge clk); #1; sample("rnd_rst");
        for (int c = 0; c < 120; c++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 3) == 0) p[b] = ~p[b];
            end
            r = ($urandom_range(0, 39) == 0);
            model_step(r, p, e);
            drive("rnd", r, p, e);
        end
        reset   = 1'b0;
        pending = 4'b0000;

        // single-channel instance, STROBE_CYCLES=1
        reset1 = 1'b1;
        @(posedge clk); #1;
        check("c1_rst", {28'd0, strobe1, done1, busy1, grant1}, 32'h0);
        reset1 = 1'b0; pending1 = 1'b1;
        @(posedge clk); #1;
        check("c1_strobe", {28'd0, strobe1, done1, busy1, grant1}, 32'b1010);
        @(posedge clk); #1;
        check("c1_done", {28'd0, strobe1, done1, busy1, grant1}, 32'b0110);
        @(posedge clk); #1;
        check("c1_done_hold", {28'd0, strobe1, done1, busy1, grant1}, 32'b0110);
        pending1 = 1'b0;
        @(posedge clk); #1;
        check("c1_idle", {28'd0, strobe1, done1, busy1, grant1}, 32'b0000);

        check("queue_drained", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
